twos_comp_seq: RTL and testbench

//  Sequential, parametrised two's-complement unit for the Position datapath: negate, absolute value,

---
 rtl/pos_arith_pkg.sv | 39 +++
 rtl/comp_chunk_add.sv | 24 ++
 rtl/twos_comp_seq.sv | 174 +++++++++++++++++
 tb/tb_twos_comp_seq.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pos_arith_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pos_arith_pkg
// Description : Shared definitions for the Position datapath arithmetic units.
//               Mode encodings, FSM state encoding and width-generic constant
//               helpers (most-negative / max-positive two's-complement words).
// Revision    : 1.0 - initial release
// ============================================================================
package pos_arith_pkg;

    // Operation modes presented on in_mode
    localparam logic [1:0] MODE_PASS = 2'b00;  // result = operand
    localparam logic [1:0] MODE_NEG  = 2'b01;  // result = -operand
    localparam logic [1:0] MODE_ABS  = 2'b10;  // result = |operand|
    localparam logic [1:0] MODE_CNEG = 2'b11;  // result = in_sgn ? -operand : operand

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Widest operand the constant helpers can describe; callers truncate
    // the returned word to their own width.
    localparam int MAX_W = 256;

    // 1000...0 in a w-bit word
    function automatic logic [MAX_W-1:0] most_neg(input int w);
        return MAX_W'(1) << (w - 1);
    endfunction

    // 0111...1 in a w-bit word
    function automatic logic [MAX_W-1:0] max_pos(input int w);
        return most_neg(w) - MAX_W'(1);
    endfunction

endpackage : pos_arith_pkg
`default_nettype wire

// File: rtl/comp_chunk_add.sv
`default_nettype none
// ============================================================================
// Module      : comp_chunk_add
// Description : CHUNK-bit incrementer slice, {o_cout, o_sum} = i_a + i_cin.
//               Used as the single carry-resolving adder of twos_comp_seq.
// Ports       : i_a    [CHUNK-1:0]  operand chunk (already conditionally inverted)
//               i_cin                carry in
//               o_sum  [CHUNK-1:0]  chunk sum
//               o_cout               carry out
// Revision    : 1.0 - initial release
// ============================================================================
module comp_chunk_add #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout
);

    assign {o_cout, o_sum} = {1'b0, i_a} + {{CHUNK{1'b0}}, i_cin};

endmodule : comp_chunk_add
`default_nettype wire

// File: rtl/twos_comp_seq.sv
`default_nettype none
// ============================================================================
// Module      : twos_comp_seq
// Description : Sequential two's-complement unit (pass / negate / abs /
//               sign-conditional negate). The +1 carry of invert-and-add-one
//               is resolved CHUNK bits per cycle, LSB chunk first, through a
//               single narrow adder. valid/ready on both sides; out_ovf flags
//               negation of the most-negative value.
// Parameters  : W      operand/result width (W >= 2)
//               CHUNK  bits resolved per RUN cycle (W % CHUNK == 0)
// Ports       : clk, rst (async, active-high)
//               in_valid / in_ready / in_data[W] / in_mode[2] / in_sgn
//               out_valid / out_ready / out_data[W] / out_ovf
// Build macro : NEG_SAT_EN - when defined, an overflowing negation returns
//               the max positive value instead of the wrapped 1000..0.
// Revision    : 1.0 - initial release
// ============================================================================
module twos_comp_seq
    import pos_arith_pkg::*;
#(
    parameter int W     = 16,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic [1:0]   in_mode,
    input  logic         in_sgn,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_ovf
);

    localparam int NCH  = W / CHUNK;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [W-1:0] c_MOST_NEG = W'(most_neg(W));
`ifdef NEG_SAT_EN
    localparam logic [W-1:0] c_MAX_POS  = W'(max_pos(W));
`endif

    state_t             r_state;
    logic [W-1:0]       r_op;
    logic [W-1:0]       r_res;
    logic               r_neg;
    logic               r_carry;
    logic               r_ovf;
    logic [IDXW-1:0]    r_idx;
    logic               r_out_valid;
    logic [W-1:0]       r_out_data;
    logic               r_out_ovf;

    logic               w_accept;
    logic               w_in_neg;
    logic [CHUNK-1:0]   w_op_chunk;
    logic [CHUNK-1:0]   w_add_a;
    logic [CHUNK-1:0]   w_sum;
    logic               w_cout;
    logic [W-1:0]       w_res_next;
    logic               w_last;
    logic [W-1:0]       w_final;

    assign in_ready = (r_state == ST_IDLE) && !rst;
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_in_neg = 1'b0;
        case (in_mode)
            MODE_NEG:  w_in_neg = 1'b1;
            MODE_ABS:  w_in_neg = in_data[W-1];
            MODE_CNEG: w_in_neg = in_sgn;
            default:   w_in_neg = 1'b0;
        endcase
    end

    // Select the operand chunk currently being resolved
    always_comb begin
        w_op_chunk = '0;
        for (int k = 0; k < NCH; k++) begin
            if (r_idx == IDXW'(k)) begin
                w_op_chunk = r_op[k*CHUNK +: CHUNK];
            end
        end
    end

    // Inversion is folded in here; the adder only ever adds the running carry
    assign w_add_a = w_op_chunk ^ {CHUNK{r_neg}};

    comp_chunk_add #(
        .CHUNK (CHUNK)
    ) u_chunk_add (
        .i_a    (w_add_a),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Write the fresh sum back into its slice of the result word
    for (genvar k = 0; k < NCH; k++) begin : g_wb
        assign w_res_next[k*CHUNK +: CHUNK] =
            (r_idx == IDXW'(k)) ? w_sum : r_res[k*CHUNK +: CHUNK];
    end

    assign w_last = (r_idx == IDXW'(NCH - 1));

`ifdef NEG_SAT_EN
    assign w_final = r_ovf ? c_MAX_POS : w_res_next;
`else
    // Wrapped result of negating 1000..0 is 1000..0 itself
    assign w_final = w_res_next;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_op        <= '0;
            r_res       <= '0;
            r_neg       <= 1'b0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op    <= in_data;
                        r_res   <= '0;
                        r_neg   <= w_in_neg;
                        r_carry <= w_in_neg;   // the "+1" of invert-and-add-one
                        r_idx   <= '0;
                        r_ovf   <= w_in_neg && (in_data == c_MOST_NEG);
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_res   <= w_res_next;
                    r_carry <= w_cout;         // carry out of the MSB chunk is dropped later
                    if (w_last) begin
                        r_idx       <= '0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_final;
                        r_out_ovf   <= r_ovf;
                        r_state     <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_data  <= '0;
                        r_out_ovf   <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ovf   = r_out_ovf;

endmodule : twos_comp_seq
`default_nettype wire

// File: tb/tb_twos_comp_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_twos_comp_seq
// Description : Directed bench for twos_comp_seq (W=16, CHUNK=4) plus a
//               single-chunk instance (W=16, CHUNK=16). Expected results are
//               queued at accept time and popped at the output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_twos_comp_seq;

    localparam int W = 16;

`ifdef NEG_SAT_EN
    localparam logic [15:0] c_OVF_RES = 16'h7FFF;
`else
    localparam logic [15:0] c_OVF_RES = 16'h8000;
`endif

    typedef struct packed {
        logic [15:0] d;
        logic        o;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;

    logic          in_valid, in_ready, in_sgn, out_valid, out_ready, out_ovf;
    logic [W-1:0]  in_data, out_data;
    logic [1:0]    in_mode;

    logic          in_valid_b, in_ready_b, in_sgn_b, out_valid_b, out_ready_b, out_ovf_b;
    logic [W-1:0]  in_data_b, out_data_b;
    logic [1:0]    in_mode_b;

    int            n_assert = 0;
    int            n_fail   = 0;
    exp_t          sb[$];

    always #5 clk = ~clk;

    twos_comp_seq #(.W(W), .CHUNK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_sgn    (in_sgn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    twos_comp_seq #(.W(W), .CHUNK(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .in_data   (in_data_b),
        .in_mode   (in_mode_b),
        .in_sgn    (in_sgn_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready_b),
        .out_data  (out_data_b),
        .out_ovf   (out_ovf_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Independent arithmetic reference for randomised operations
    function automatic exp_t model(input logic [15:0] d, input logic [1:0] m, input logic s);
        exp_t e;
        logic neg;
        neg = (m == 2'b01) || ((m == 2'b10) && d[15]) || ((m == 2'b11) && s);
        e.d = neg ? (16'h0000 - d) : d;
        e.o = neg && (d == 16'h8000);
        if (e.o) e.d = c_OVF_RES;
        return e;
    endfunction

    // Offer one operand; the accept edge is the one this task waits on
    task automatic send(input string tag, input logic [15:0] d, input logic [1:0] m,
                        input logic s, input exp_t e);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        in_sgn   = s;
        sb.push_back(e);
        step();
        in_valid = 1'b0;
        in_data  = 16'(~d);
        in_mode  = ~m;
        in_sgn   = ~s;
    endtask

    // Count edges after the accept edge until out_valid; exp_lat < 0 skips latency check
    task automatic wait_out(input string tag, input int exp_lat);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        if (exp_lat >= 0) chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    endtask

    task automatic take(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s_scoreboard: observed empty expected entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_data"}, 32'(out_data), 32'(e.d));
            chk({tag, "_ovf"},  32'(out_ovf),  32'(e.o));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_ready_after"}, 32'(in_ready),  32'd1);
        chk({tag, "_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        exp_t        e;
        logic [15:0] d;
        logic [1:0]  m;
        logic        s;

        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_mode = '0; in_sgn = 1'b0; out_ready = 1'b0;
        in_valid_b = 1'b0; in_data_b = '0; in_mode_b = '0; in_sgn_b = 1'b0; out_ready_b = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_ovf",   32'(out_ovf),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // Negate, abs, conditional negate; out_valid 4 edges after the accept edge
        send("neg5", 16'h0005, 2'b01, 1'b0, '{16'hFFFB, 1'b0});
        wait_out("neg5", 4);
        take("neg5");
        send("abs_fff0", 16'hFFF0, 2'b10, 1'b0, '{16'h0010, 1'b0});
        wait_out("abs_fff0", 4);
        take("abs_fff0");
        send("abs_7", 16'h0007, 2'b10, 1'b1, '{16'h0007, 1'b0});
        wait_out("abs_7", 4);
        take("abs_7");
        send("cneg_3", 16'h0003, 2'b11, 1'b1, '{16'hFFFD, 1'b0});
        wait_out("cneg_3", 4);
        take("cneg_3");
        send("pass", 16'hA5C3, 2'b00, 1'b1, '{16'hA5C3, 1'b0});
        wait_out("pass", 4);
        take("pass");

        // Most-negative overflow and negate-zero (full carry ripple)
        send("ovf", 16'h8000, 2'b01, 1'b0, '{c_OVF_RES, 1'b1});
        wait_out("ovf", 4);
        take("ovf");
        send("neg0", 16'h0000, 2'b01, 1'b0, '{16'h0000, 1'b0});
        wait_out("neg0", 4);
        take("neg0");

        // Single-chunk instance: result one edge after accept
        chk("c16_in_ready", 32'(in_ready_b), 32'd1);
        in_valid_b = 1'b1; in_data_b = 16'h0000; in_mode_b = 2'b01;
        step();
        in_valid_b = 1'b0;
        chk("c16_run_valid", 32'(out_valid_b), 32'd0);
        step();
        chk("c16_valid", 32'(out_valid_b), 32'd1);
        chk("c16_data",  32'(out_data_b),  32'h0000);
        chk("c16_ovf",   32'(out_ovf_b),   32'd0);
        out_ready_b = 1'b1;
        step();
        out_ready_b = 1'b0;
        chk("c16_ready_after", 32'(in_ready_b), 32'd1);
        in_valid_b = 1'b1; in_data_b = 16'h0005; in_mode_b = 2'b01;
        step();
        in_valid_b = 1'b0;
        step();
        chk("c16_neg5_valid", 32'(out_valid_b), 32'd1);
        chk("c16_neg5_data",  32'(out_data_b),  32'hFFFB);
        out_ready_b = 1'b1;
        step();
        out_ready_b = 1'b0;

        // Back-pressure in DONE: outputs hold, inputs ignored
        send("bp", 16'h00F0, 2'b01, 1'b0, '{16'hFF10, 1'b0});
        wait_out("bp", 4);
        for (int i = 0; i < 6; i++) begin
            in_valid = i[0];
            in_data  = 16'($urandom);
            in_mode  = 2'b01;
            step();
            chk("bp_hold_data",  32'(out_data),  32'hFF10);
            chk("bp_hold_ovf",   32'(out_ovf),   32'd0);
            chk("bp_in_ready",   32'(in_ready),  32'd0);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        take("bp");

        // Reset in the middle of RUN discards the operation
        send("mid", 16'h0F0F, 2'b01, 1'b0, '{16'hF0F1, 1'b0});
        step();
        rst = 1'b1;
        #1;
        sb.delete();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data",  32'(out_data),  32'd0);
        chk("mid_rst_ready", 32'(in_ready),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rel_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("mid_no_valid", 32'(out_valid), 32'd0);
        end
        send("after_rst", 16'h1234, 2'b01, 1'b0, '{16'hEDCC, 1'b0});
        wait_out("after_rst", 4);
        take("after_rst");

        // Randomised operations against the arithmetic reference
        for (int i = 0; i < 12; i++) begin
            d = 16'($urandom);
            if (i == 3) d = 16'h8000;
            m = 2'($urandom_range(0, 3));
            s = 1'($urandom_range(0, 1));
            e = model(d, m, s);
            send("rnd", d, m, s, e);
            wait_out("rnd", 4);
            take("rnd");
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_twos_comp_seq
`default_nettype wire
